// File: rtl/reduce_gate_pkg.sv
// Shared mode encodings and helpers for the pipelined N-input reduction gate.
package reduce_gate_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } red_mode_t;

  // Encodings 6 and 7 have no function attached.
  function automatic logic is_legal_mode(input logic [2:0] mode);
    return (mode <= 3'd5);
  endfunction

endpackage

// File: rtl/reduce_gate_core.sv
// Combinational N-input reduction selected by mode; illegal modes yield 0.
module reduce_gate_core
  import reduce_gate_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] a,
  input  logic [2:0]      mode,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (mode)
      MODE_AND:  y = &a;
      MODE_OR:   y = |a;
      MODE_XOR:  y = ^a;
      MODE_NAND: y = ~&a;
      MODE_NOR:  y = ~|a;
      MODE_XNOR: y = ~^a;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Two-stage valid/ready pipeline around reduce_gate_core, with a saturating
// count of delivered one-results and a sticky illegal-mode flag.
module reduce_gate_pipe
  import reduce_gate_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [2:0]       out_mode,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             err_mode
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            s1_valid;
  logic [N_IN-1:0] s1_data;
  logic [2:0]      s1_mode;
  logic            s2_valid;
  logic            core_y;
  logic            adv1;
  logic            adv2;
  logic            in_xfer;
  logic            out_xfer;

  // Ready is derived only from registered occupancy and out_ready.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_mode  <= in_mode;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  reduce_gate_core #(
    .N_IN (N_IN)
  ) u_core (
    .a    (s1_data),
    .mode (s1_mode),
    .y    (core_y)
  );

  // Result registers only move when downstream has room, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_y    <= 1'b0;
      out_mode <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_y    <= core_y;
        out_mode <= s1_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (out_xfer && out_y && (ones_cnt != CNT_MAX)) begin
      ones_cnt <= ones_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_mode <= 1'b0;
    end else if (in_xfer && !is_legal_mode(in_mode)) begin
      err_mode <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Randomized and scripted checks of reduce_gate_pipe against a counting-based reference model.
module tb_reduce_gate_pipe;
  import reduce_gate_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y, a_err_mode;
  logic [2:0] a_in_data, a_in_mode, a_out_mode;
  logic [7:0] a_ones_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y, b_err_mode;
  logic [7:0] b_in_data;
  logic [2:0] b_in_mode, b_out_mode;
  logic [1:0] b_ones_cnt;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  typedef struct {
    logic       y;
    logic [2:0] mode;
    int         k;
  } item_t;

  item_t exp_q[$];
  int    m_cnt = 0;
  logic  m_err = 1'b0;

  reduce_gate_pipe #(.N_IN(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_y(a_out_y), .out_mode(a_out_mode),
    .ones_cnt(a_ones_cnt), .err_mode(a_err_mode)
  );

  reduce_gate_pipe #(.N_IN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_y(b_out_y), .out_mode(b_out_mode),
    .ones_cnt(b_ones_cnt), .err_mode(b_err_mode)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference: count the ones, then decide the function from the count.
  function automatic logic ref_y(input logic [63:0] a, input int n, input logic [2:0] mode);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(a[i]);
    case (mode)
      3'd0: return ones == n;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != n;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle on instance A with scoreboard checks of ready, valid, result, counter and flag.
  task automatic step_a(input logic v, input logic [2:0] d, input logic [2:0] m, input logic r);
    logic  exp_rdy, exp_ov;
    item_t it;
    @(negedge clk);
    a_in_valid = v; a_in_data = d; a_in_mode = m; a_out_ready = r;
    #1;
    exp_rdy = (exp_q.size() < 2) || r;
    exp_ov  = (exp_q.size() > 0) && (edge_n >= exp_q[0].k + 2);
    checks++;
    if (a_in_ready !== exp_rdy) begin
      failures++; $display("[TB] FAIL a_in_ready: got %b expected %b", a_in_ready, exp_rdy);
    end
    checks++;
    if (a_out_valid !== exp_ov) begin
      failures++; $display("[TB] FAIL a_out_valid: got %b expected %b", a_out_valid, exp_ov);
    end
    checks++;
    if (a_ones_cnt !== 8'(m_cnt)) begin
      failures++; $display("[TB] FAIL a_ones_cnt: got %0d expected %0d", a_ones_cnt, m_cnt);
    end
    checks++;
    if (a_err_mode !== m_err) begin
      failures++; $display("[TB] FAIL a_err_mode: got %b expected %b", a_err_mode, m_err);
    end
    if (exp_ov) begin
      checks++;
      if (a_out_y !== exp_q[0].y || a_out_mode !== exp_q[0].mode) begin
        failures++;
        $display("[TB] FAIL a_result: got y=%b mode=%0d expected y=%b mode=%0d",
                 a_out_y, a_out_mode, exp_q[0].y, exp_q[0].mode);
      end
      if (r) begin
        if (exp_q[0].y && m_cnt < 255) m_cnt++;
        void'(exp_q.pop_front());
      end
    end
    if (v && exp_rdy) begin
      it.y = ref_y(64'(d), 3, m); it.mode = m; it.k = edge_n;
      exp_q.push_back(it);
      if (m > 3'd5) m_err = 1'b1;
    end
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic [2:0] m, input logic r);
    @(negedge clk);
    b_in_valid = v; b_in_data = d; b_in_mode = m; b_out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_y !== 1'b0 || a_out_mode !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_a_out: got v=%b y=%b mode=%0d expected 0 0 0",
                           a_out_valid, a_out_y, a_out_mode);
    end
    checks++;
    if (a_ones_cnt !== 8'd0 || a_err_mode !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_a_state: got cnt=%0d err=%b rdy=%b expected 0 0 1",
                           a_ones_cnt, a_err_mode, a_in_ready);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_ones_cnt !== 2'd0 || b_err_mode !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_b: got v=%b cnt=%0d err=%b expected 0 0 0",
                           b_out_valid, b_ones_cnt, b_err_mode);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    for (int m = 0; m < 6; m++)
      for (int d = 0; d < 8; d++)
        step_a(1'b1, 3'(d), 3'(m), 1'b1);
    repeat (3) step_a(1'b0, 3'd0, 3'd0, 1'b1);
    checks++;
    if (a_ones_cnt !== 8'd24) begin
      failures++; $display("[TB] FAIL sweep_total: got %0d expected 24", a_ones_cnt);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++)
      step_a(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)),
             ($urandom_range(0, 3) != 0));
    repeat (4) step_a(1'b0, 3'd0, 3'd0, 1'b1);
  endtask

  task automatic test_illegal;
    step_a(1'b1, 3'b111, 3'd7, 1'b1);
    repeat (2) step_a(1'b0, 3'd0, 3'd0, 1'b1);
    checks++;
    if (a_err_mode !== 1'b1) begin
      failures++; $display("[TB] FAIL illegal_flag: got %b expected 1", a_err_mode);
    end
    for (int c = 0; c < 8; c++)
      step_a(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 1'b1);
    repeat (3) step_a(1'b0, 3'd0, 3'd0, 1'b1);
    checks++;
    if (a_err_mode !== 1'b1) begin
      failures++; $display("[TB] FAIL illegal_sticky: got %b expected 1", a_err_mode);
    end
  endtask

  task automatic test_reset_mid;
    repeat (3) step_a(1'b1, 3'b111, MODE_AND, 1'b0);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL full_before_reset: got rdy=%b v=%b expected 0 1",
                           a_in_ready, a_out_valid);
    end
    @(negedge clk);
    rst = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_in_valid = 1'b0;
    #1;
    exp_q.delete(); m_cnt = 0; m_err = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_ones_cnt !== 8'd0 || a_err_mode !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_mid: got v=%b cnt=%0d err=%b rdy=%b expected 0 0 0 1",
                           a_out_valid, a_ones_cnt, a_err_mode, a_in_ready);
    end
    step_a(1'b1, 3'b111, MODE_AND, 1'b1);
    step_a(1'b0, 3'd0, 3'd0, 1'b1);
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL post_reset_early: got v=%b expected 0", a_out_valid);
    end
    step_a(1'b0, 3'd0, 3'd0, 1'b1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_y !== 1'b1) begin
      failures++; $display("[TB] FAIL post_reset_result: got v=%b y=%b expected 1 1",
                           a_out_valid, a_out_y);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_c [8];
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int j = 0; j < 8; j++) begin
      step_b(j < 5, 8'hFF, MODE_AND, 1'b1);
      checks++;
      if (b_ones_cnt !== exp_c[j]) begin
        failures++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", j, b_ones_cnt, exp_c[j]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] stream [3];
    logic       exp_rdy [5];
    logic       got [$];
    int         idx = 0;
    stream  = '{8'h00, 8'h01, 8'h80};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      step_b(1'b1, stream[idx], MODE_OR, 1'b0);
      checks++;
      if (b_in_ready !== exp_rdy[c]) begin
        failures++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", c, b_in_ready, exp_rdy[c]);
      end
      if (c >= 2) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_y !== 1'b0) begin
          failures++; $display("[TB] FAIL bp_hold[%0d]: got v=%b y=%b expected 1 0", c, b_out_valid, b_out_y);
        end
      end
      if (b_in_ready && idx < 2) idx++;
      else if (b_in_ready) idx = 3;
    end
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      step_b(idx < 3, (idx < 3) ? stream[idx % 3] : 8'h00, MODE_OR, 1'b1);
      if (b_out_valid) got.push_back(b_out_y);
      if (idx < 3 && b_in_ready) idx++;
    end
    step_b(1'b0, 8'h00, MODE_OR, 1'b1);
    checks++;
    if (got.size() != 3) begin
      failures++; $display("[TB] FAIL bp_count: got %0d results expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== ref_y(64'(stream[i]), 8, MODE_OR)) begin
          failures++; $display("[TB] FAIL bp_order[%0d]: got %b expected %b", i, got[i],
                               ref_y(64'(stream[i]), 8, MODE_OR));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b0;
    test_reset;
    test_sweep;
    test_random;
    test_illegal;
    test_reset_mid;
    test_saturation;
    test_backpressure;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
